// File: rtl/loopback_rd2wr_stage.sv
// Loopback read-to-write stage: buffers in-order read responses in a FIFO and replays them as indexed writes (optional LOOPBACK_RD2WR_CHECKSUM_EN).
// Latency: a response accepted into an empty FIFO is presented as a write request on the next cycle.
// Backpressure: write side stalls on !ready; read side throttled via rd_almost_full, responses that cannot be stored are dropped and flagged in err.
module loopback_rd2wr_stage #(
    parameter int DATA_W       = 512,
    parameter int DEPTH        = 64,
    parameter int CNT_W        = 32,
    parameter int AFULL_MARGIN = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_num_lines,
    input  logic              i_rd_rsp_valid,
    input  logic [DATA_W-1:0] i_rd_rsp_data,
    output logic              o_rd_almost_full,
    output logic              o_wr_req_valid,
    output logic [CNT_W-1:0]  o_wr_req_line,
    output logic [DATA_W-1:0] o_wr_req_data,
    input  logic              i_wr_req_ready,
`ifdef LOOPBACK_RD2WR_CHECKSUM_EN
    output logic [31:0]       o_checksum,
`endif
    output logic              o_done,
    output logic              o_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_target, r_rx_cnt, r_wr_cnt;
    logic [AW-1:0]     r_wptr, r_rptr;
    logic [OW-1:0]     r_occ;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_run, w_empty, w_full, w_start_ok;
    logic              w_push, w_pop, w_drop, w_last_pop;
    logic [DATA_W-1:0] w_head;

    assign w_run      = (r_state == S_RUN);
    assign w_empty    = (r_occ == '0);
    assign w_full     = (r_occ == OW'(DEPTH));
    assign w_start_ok = i_start && !w_run;
    assign w_head     = r_mem[r_rptr];
    assign w_pop      = w_run && !w_empty && i_wr_req_ready;
    // A full FIFO can still take a response when the head leaves in the same cycle.
    assign w_push     = w_run && i_rd_rsp_valid && (r_rx_cnt != r_target) && (!w_full || w_pop);
    assign w_drop     = i_rd_rsp_valid && !w_push;
    assign w_last_pop = w_pop && (r_wr_cnt == r_target - CNT_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_nxt = (i_num_lines == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_pop) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_target <= '0;
            r_rx_cnt <= '0;
            r_wr_cnt <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_occ    <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_drop) begin
                r_err <= 1'b1;
            end
            if (w_start_ok) begin
                r_target <= i_num_lines;
                r_rx_cnt <= '0;
                r_wr_cnt <= '0;
                r_wptr   <= '0;
                r_rptr   <= '0;
                r_occ    <= '0;
            end else begin
                if (w_push) begin
                    r_wptr   <= r_wptr + AW'(1);
                    r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                end
                if (w_pop) begin
                    r_rptr   <= r_rptr + AW'(1);
                    r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_occ <= r_occ + OW'(1);
                end else if (w_pop && !w_push) begin
                    r_occ <= r_occ - OW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_rd_rsp_data;
        end
    end

`ifdef LOOPBACK_RD2WR_CHECKSUM_EN
    function automatic logic [31:0] f_fold(input logic [DATA_W-1:0] d);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < DATA_W / 32; i++) begin
            acc ^= d[i*32 +: 32];
        end
        return acc;
    endfunction

    logic [31:0] r_csum;

    always_ff @(posedge i_clk) begin
        if (i_reset || w_start_ok) begin
            r_csum <= '0;
        end else if (w_pop) begin
            r_csum <= r_csum ^ f_fold(w_head);
        end
    end

    assign o_checksum = r_csum;
`endif

    assign o_wr_req_valid   = w_run && !w_empty;
    assign o_wr_req_data    = o_wr_req_valid ? w_head : '0;
    assign o_wr_req_line    = r_wr_cnt;
    assign o_rd_almost_full = w_run && (r_occ >= OW'(DEPTH - AFULL_MARGIN));
    assign o_done           = (r_state == S_DONE);
    assign o_err            = r_err;

endmodule
